// File: rtl/exec_unit_if.sv
// Issue, register-file and write-back signals of the execute stage.
// The environment (issuer plus register file) takes the master side; exec_unit takes the slave side.
interface exec_unit_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             issue_valid;
  logic             issue_ready;
  logic [2:0]       issue_op;
  logic [AW-1:0]    issue_srcA;
  logic [AW-1:0]    issue_srcB;
  logic [AW-1:0]    issue_dst;
  logic [AW-1:0]    read_addrA;
  logic [AW-1:0]    read_addrB;
  logic [WIDTH-1:0] read_dataA;
  logic [WIDTH-1:0] read_dataB;
  logic             write_en;
  logic [AW-1:0]    write_addr;
  logic [WIDTH-1:0] write_data;
  logic             busy;
  logic             flag_z;
  logic             flag_c;

  modport master (
    output issue_valid, issue_op, issue_srcA, issue_srcB, issue_dst,
    output read_dataA, read_dataB,
    input  issue_ready, read_addrA, read_addrB,
    input  write_en, write_addr, write_data, busy, flag_z, flag_c
  );

  modport slave (
    input  issue_valid, issue_op, issue_srcA, issue_srcB, issue_dst,
    input  read_dataA, read_dataB,
    output issue_ready, read_addrA, read_addrB,
    output write_en, write_addr, write_data, busy, flag_z, flag_c
  );
endinterface

// File: rtl/exec_unit.sv
// Single-issue execute stage: latches operands at accept, runs a one-cycle ALU op or a
// WIDTH-cycle shift-add multiply, then emits one write-back strobe and updates Z/C flags.
module exec_unit #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        RESET,
  exec_unit_if.slave  io
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_e;

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [AW-1:0]      dst_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               flag_z_q, flag_c_q;

  logic [WIDTH-1:0]   res_d;
  logic               carry_d;
  logic [WIDTH:0]     sum_w;
  logic               accept_w;

  assign sum_w    = {1'b0, a_q} + {1'b0, b_q};
  assign accept_w = io.issue_valid & io.issue_ready;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        res_d   = sum_w[WIDTH-1:0];
        carry_d = sum_w[WIDTH];
      end
      OP_SUB: begin
        res_d   = a_q - b_q;
        carry_d = (a_q < b_q);
      end
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_XOR: res_d = a_q ^ b_q;
      OP_SHL: res_d = a_q << b_q[CW-1:0];
      OP_SHR: res_d = a_q >> b_q[CW-1:0];
      OP_MUL: begin
        res_d   = acc_q[WIDTH-1:0];
        carry_d = |acc_q[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath latches and accumulator are reset too, since reset must clear all state.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_w) begin
            a_q     <= io.read_dataA;
            b_q     <= io.read_dataB;
            op_q    <= op_e'(io.issue_op);
            dst_q   <= io.issue_dst;
            cnt_q   <= '0;
            acc_q   <= '0;
            state_q <= (op_e'(io.issue_op) == OP_MUL) ? EXEC : WB;
          end
        end
        EXEC: begin
          // One multiplier bit per cycle, LSB first; partial product is A shifted by bit index.
          if (b_q[cnt_q]) begin
            acc_q <= acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= WB;
          end
        end
        WB: begin
          flag_z_q <= (res_d == '0);
          flag_c_q <= carry_d;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.issue_ready = (state_q == IDLE) & ~RESET;
  assign io.busy        = (state_q != IDLE);
  assign io.read_addrA  = io.issue_srcA;
  assign io.read_addrB  = io.issue_srcB;
  assign io.write_en    = (state_q == WB);
  assign io.write_addr  = (state_q == WB) ? dst_q : '0;
  assign io.write_data  = (state_q == WB) ? res_d : '0;
  assign io.flag_z      = flag_z_q;
  assign io.flag_c      = flag_c_q;
endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: behavioural register file, directed vector table, multi-cycle
// corner sequences (back-to-back dependency, reset mid-multiply) and randomized ops vs. a model.
module tb_exec_unit;
  logic clk = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  exec_unit_if #(.WIDTH(16), .AW(4)) bus ();

  exec_unit #(.WIDTH(16), .AW(4)) dut (
    .clk   (clk),
    .RESET (RESET),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  // Register file: combinational reads, write on rising edge; bench preloads through a poke port.
  logic [15:0] rf [16];
  logic        pk_en;
  logic [3:0]  pk_addr;
  logic [15:0] pk_data;

  assign bus.read_dataA = rf[bus.read_addrA];
  assign bus.read_dataB = rf[bus.read_addrB];

  always @(posedge clk) begin
    if (pk_en)        rf[pk_addr]        <= pk_data;
    if (bus.write_en) rf[bus.write_addr] <= bus.write_data;
  end

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [3:0]  dst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_d;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour from the opcode rules, using plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c);
    int unsigned wide;
    int unsigned sh;
    sh = b % 16;
    c  = 1'b0;
    r  = '0;
    case (op)
      3'd0: begin wide = a + b; r = 16'(wide); c = (wide > 65535); end
      3'd1: begin r = 16'((32'(a) + 65536 - 32'(b)) % 65536); c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = 16'((32'(a) * (32'd1 << sh)) % 65536);
      3'd6: r = 16'(32'(a) / (32'd1 << sh));
      default: begin wide = 32'(a) * 32'(b); r = 16'(wide % 65536); c = (wide > 65535); end
    endcase
  endfunction

  // Called and returns at a negedge.
  task automatic poke(input logic [3:0] addr, input logic [15:0] data);
    pk_en = 1'b1; pk_addr = addr; pk_data = data;
    @(posedge clk);
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // Issue one instruction at the current negedge (issue_valid held while busy) and check retirement.
  task automatic run(input vec_t v, input string name, input bit preload);
    int k;
    int extra;
    bit found;
    if (preload) begin
      poke(v.sa, v.a);
      poke(v.sb, v.b);
    end
    bus.issue_valid = 1'b1;
    bus.issue_op    = v.op;
    bus.issue_srcA  = v.sa;
    bus.issue_srcB  = v.sb;
    bus.issue_dst   = v.dst;
    check({name, ".ready_at_issue"}, 32'(bus.issue_ready), 32'd1);
    check({name, ".read_addr"}, {24'd0, bus.read_addrB, bus.read_addrA}, {24'd0, v.sb, v.sa});
    @(posedge clk);
    k = 0; extra = 0; found = 1'b0;
    while (k < 40) begin
      @(negedge clk);
      if (bus.issue_valid && bus.issue_ready) extra++;
      if (bus.write_en) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      k++;
    end
    check({name, ".write_seen"}, 32'(found), 32'd1);
    check({name, ".latency"}, k + 1, (v.op == 3'd7) ? 17 : 1);
    check({name, ".busy_in_wb"}, 32'(bus.busy), 32'd1);
    check({name, ".write_addr"}, 32'(bus.write_addr), 32'(v.dst));
    check({name, ".write_data"}, 32'(bus.write_data), 32'(v.exp_d));
    @(posedge clk);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    check({name, ".extra_accepts"}, extra, 0);
    check({name, ".strobe_one_cycle"}, {31'd0, bus.write_en}, 32'd0);
    check({name, ".idle_bus_zero"}, {12'd0, bus.write_addr, bus.write_data}, 32'd0);
    check({name, ".ready_after"}, 32'(bus.issue_ready), 32'd1);
    check({name, ".flags"}, {30'd0, bus.flag_z, bus.flag_c}, {30'd0, v.exp_z, v.exp_c});
    check({name, ".rf_dst"}, 32'(rf[v.dst]), 32'(v.exp_d));
  endtask

  initial begin
    vec_t v;
    int   wr_seen;
    logic [15:0] r;
    logic        c;

    // op, sa, sb, dst, a, b, result, C, Z
    tbl[0]  = '{3'd0, 4'd1,  4'd2,  4'd3,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};
    tbl[1]  = '{3'd0, 4'd1,  4'd2,  4'd3,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[2]  = '{3'd1, 4'd5,  4'd6,  4'd4,  16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
    tbl[3]  = '{3'd5, 4'd1,  4'd2,  4'd7,  16'h00F1, 16'h0014, 16'h0F10, 1'b0, 1'b0};
    tbl[4]  = '{3'd6, 4'd8,  4'd9,  4'd10, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0};
    tbl[5]  = '{3'd7, 4'd11, 4'd12, 4'd13, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0};
    tbl[6]  = '{3'd7, 4'd11, 4'd12, 4'd0,  16'h1000, 16'h0010, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{3'd2, 4'd2,  4'd3,  4'd14, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
    tbl[8]  = '{3'd3, 4'd4,  4'd5,  4'd15, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 1'b0};
    tbl[9]  = '{3'd4, 4'd6,  4'd7,  4'd1,  16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1};
    tbl[10] = '{3'd1, 4'd8,  4'd9,  4'd2,  16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{3'd0, 4'd10, 4'd11, 4'd12, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};

    RESET = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_op = '0; bus.issue_srcA = '0; bus.issue_srcB = '0; bus.issue_dst = '0;
    pk_en = 1'b0; pk_addr = '0; pk_data = '0;
    for (int i = 0; i < 16; i++) rf[i] = '0;

    #1;
    check("reset.ready_low_in_reset", 32'(bus.issue_ready), 32'd0);
    @(negedge clk); @(negedge clk);
    RESET = 1'b0;
    #1;
    check("reset.ready", 32'(bus.issue_ready), 32'd1);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.write_bus", {11'd0, bus.write_en, bus.write_addr, bus.write_data}, 32'd0);
    check("reset.flags", {30'd0, bus.flag_z, bus.flag_c}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i), 1'b1);

    // Back-to-back dependency: r1 = r2 + r3, then immediately r4 = r1 + r1.
    v = '{3'd0, 4'd2, 4'd3, 4'd1, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0};
    run(v, "b2b.first", 1'b1);
    v = '{3'd0, 4'd1, 4'd1, 4'd4, 16'h0030, 16'h0030, 16'h0060, 1'b0, 1'b0};
    run(v, "b2b.second", 1'b0);

    // Set both flags, then reset at EXEC cycle 8 of a MUL into r8.
    v = '{3'd0, 4'd1, 4'd2, 4'd3, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    run(v, "pre_reset", 1'b1);
    poke(4'd8, 16'h1234);
    poke(4'd9, 16'h0003);
    poke(4'd10, 16'h0005);
    bus.issue_valid = 1'b1; bus.issue_op = 3'd7;
    bus.issue_srcA = 4'd9; bus.issue_srcB = 4'd10; bus.issue_dst = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.issue_valid = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus.write_en) wr_seen++;
    end
    check("rst_mid.busy_before", 32'(bus.busy), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_mid.bus_cleared", {11'd0, bus.write_en, bus.write_addr, bus.write_data}, 32'd0);
    check("rst_mid.flags_cleared", {30'd0, bus.flag_z, bus.flag_c}, 32'd0);
    @(negedge clk); @(negedge clk);
    RESET = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus.write_en) wr_seen++;
    end
    check("rst_mid.no_write", wr_seen, 0);
    check("rst_mid.ready", 32'(bus.issue_ready), 32'd1);
    check("rst_mid.flags", {30'd0, bus.flag_z, bus.flag_c}, 32'd0);
    check("rst_mid.rf_unchanged", 32'(rf[8]), 32'h1234);

    // Randomized instructions checked against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      v.op    = 3'($urandom_range(0, 7));
      v.sa    = 4'($urandom_range(0, 15));
      v.sb    = 4'((v.sa + $urandom_range(1, 15)) % 16);
      v.dst   = 4'($urandom_range(0, 15));
      v.a     = 16'($urandom);
      v.b     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 31)) : 16'($urandom);
      model(v.op, v.a, v.b, r, c);
      v.exp_d = r;
      v.exp_c = c;
      v.exp_z = (r == 16'd0);
      run(v, $sformatf("rand%0d_op%0d", i, v.op), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Single-issue execute stage sitting directly upstream of the 16-entry × 16-bit two-read/one-write register file. It accepts one instruction at a time, with source/destination register numbers and an opcode. It drives the register file read addresses, captures both operands, and computes an ALU or multi-cycle multiply result. It then produces the one-cycle write-back strobe (`write_en`, `write_addr`, `write_data`) that the register file consumes, and updates zero/carry flags.

## Interface
- `WIDTH`, 16, datapath width; equals register file data width
- `AW`, 4, register address width; 2**AW registers
- `clk`  in  1  single clock; all state updates on rising edge
- `RESET`  in  1  reset, asynchronous and active-high; clears all state immediately
- `issue_valid`  in  1  instruction present on `issue_*`
- `issue_ready`  out  1  block can accept; high only in IDLE
- `issue_op`  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- `issue_srcA`, `issue_srcB`  in  AW  source register numbers
- `issue_dst`  in  AW  destination register number
- `read_addrA`, `read_addrB`  out  AW  to register file; combinational copies of `issue_srcA` / `issue_srcB`
- `read_dataA`, `read_dataB`  in  WIDTH  operands from register file (combinational read)
- `write_en`  out  1  write-back strobe to register file
- `write_addr`  out  AW  write-back register number
- `write_data`  out  WIDTH  write-back value
- `busy`  out  1  high in EXEC or WB
- `flag_z`, `flag_c`  out  1  zero / carry flags from last retired instruction

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE -> WB on accept (`issue_valid & issue_ready`) for op 0–6. IDLE -> EXEC on accept for MUL.
- EXEC -> WB after exactly WIDTH EXEC cycles. WB -> IDLE always.
- At the accept edge the block latches `read_dataA`, `read_dataB`, op and dst. Issue inputs may change afterwards.
- Single-cycle result is computed in the WB cycle from the latched operands:
  - ADD: A+B, C = bit WIDTH of the WIDTH+1-bit sum.
  - SUB: A−B mod 2^WIDTH, C = 1 when A < B (unsigned borrow).
  - AND/OR/XOR: bitwise, C = 0.
  - SHL/SHR: logical shift of A by B[3:0]; vacated bits are 0; C = 0; B[15:4] is ignored.
- MUL is an unsigned shift-add over a 2·WIDTH-bit accumulator, one multiplier bit per EXEC cycle, LSB first. A 4-bit iteration counter starts at 0 and leaves EXEC when it reaches 15.
  - Result = product[15:0].
  - C = OR of product[31:16] (overflow).
- Flag timing: `flag_z` = (result == 0) and `flag_c` are updated at the WB exit edge, together with the register file write.
- Any destination, including register 0, is writable.
- No forwarding is needed. The next accept occurs no earlier than the edge after WB, so the register file already holds the new value.
- RESET, at any time including mid-EXEC or in WB:
  - state goes to IDLE; counter, accumulator, latches and flags go to 0;
  - the in-flight instruction is dropped and no write occurs.
- `issue_valid` while not ready is ignored. Upstream holds the instruction until ready.

## Timing
- Reset values: `issue_ready` = 1, `busy` = 0, `write_en` = 0, `write_addr` = 0, `write_data` = 0, `flag_z` = 0, `flag_c` = 0.
- `write_en` is 1 only in WB, and for exactly one cycle per instruction.
- `write_addr` / `write_data` are 0 outside WB.
- Single-cycle op accepted at edge T: WB is cycle T..T+1, the register file writes at edge T+1, `issue_ready` is high again after T+1. Throughput is 1 instruction per 2 cycles.
- MUL accepted at edge T: EXEC for 16 cycles, WB for cycle T+16..T+17, register file write at edge T+17. Issue-to-retire latency is 17 cycles.
- `issue_ready` = (state == IDLE) & !RESET. `busy` = !`issue_ready` while out of reset.
- `read_addrA` / `read_addrB` have zero latency. The operand path is combinational through the register file within one cycle.

## Test plan
- Reset, then ADD r3 = r1 + r2 with r1 = 0x7FFF, r2 = 0x0001 -> one `write_en` pulse, addr 3, data 0x8000, C = 0, Z = 0, two cycles after accept ready is high again.
- ADD with r1 = 0xFFFF, r2 = 0x0001 -> data 0x0000, Z = 1, C = 1. Then SUB r4 = r5 − r6 with 0x0003 − 0x0005 -> 0xFFFE, C = 1, Z = 0.
- SHL r7 = r1 << r2 with r1 = 0x00F1, r2 = 0x0014 -> shift by 4 -> 0x0F10. SHR of 0x8000 by 15 -> 0x0001.
- MUL with 0x0123 × 0x0045 -> `write_en` exactly 17 cycles after accept, data 0x4E6F, C = 0. MUL with 0x1000 × 0x0010 -> data 0x0000, C = 1, Z = 1.
- Back-to-back: write r1 via ADD, immediately issue an ADD reading r1 -> the second result uses the new r1. `issue_valid` held during busy -> exactly one accept per instruction.
- Assert RESET at EXEC cycle 8 of a MUL -> no `write_en` pulse, flags 0, `issue_ready` = 1 after release, the destination register is unchanged.
